// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the iterative IEEE-754 multiplier and its rounding unit.
// Widths are passed to the helper functions so that other FP blocks can reuse them.
package fp_mul_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rmode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        FC_ZERO = 3'd0,
        FC_SUB  = 3'd1,
        FC_NORM = 3'd2,
        FC_INF  = 3'd3,
        FC_QNAN = 3'd4,
        FC_SNAN = 3'd5
    } fp_class_e;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        logic [63:0] ones;
        ones = (64'd1 << exp_w) - 64'd1;
        return (ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_zero, input logic frac_msb);
        if (exp_zero) return frac_zero ? FC_ZERO : FC_SUB;
        if (!exp_ones) return FC_NORM;
        if (frac_zero) return FC_INF;
        return frac_msb ? FC_QNAN : FC_SNAN;
    endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result bus of the sequential multiplier.
// Both directions use valid/ready: a transfer happens on a rising edge where valid and ready are both high; the source holds its data stable until then.
interface fp_mul_seq_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] fp_X;
    logic [W-1:0] fp_Y;
    logic [2:0]   r_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] fp_Z;
    logic         ovrf;
    logic         udrf;
    logic         nv;

    modport master (
        output in_valid, fp_X, fp_Y, r_mode, out_ready,
        input  in_ready, out_valid, fp_Z, ovrf, udrf, nv
    );

    modport slave (
        input  in_valid, fp_X, fp_Y, r_mode, out_ready,
        output in_ready, out_valid, fp_Z, ovrf, udrf, nv
    );
endinterface

// File: rtl/fp_round.sv
// Rounding decision for FP datapaths: increment from G/R/S/L and sign, plus
// whether an overflowing result saturates to infinity or to the largest finite value.
module fp_round
    import fp_mul_pkg::*;
(
    input  logic       sign,
    input  logic       guard,
    input  logic       round_bit,
    input  logic       sticky,
    input  logic       lsb,
    input  logic [2:0] r_mode,
    output logic       inc,
    output logic       sat_inf
);

    logic inexact;

    assign inexact = guard | round_bit | sticky;

    // Unlisted encodings fall through to round-to-nearest-even.
    always_comb begin
        inc     = guard & (round_bit | sticky | lsb);
        sat_inf = 1'b1;
        case (r_mode)
            RM_RTZ: begin
                inc     = 1'b0;
                sat_inf = 1'b0;
            end
            RM_RDN: begin
                inc     = sign & inexact;
                sat_inf = sign;
            end
            RM_RUP: begin
                inc     = ~sign & inexact;
                sat_inf = ~sign;
            end
            RM_RMM: begin
                inc     = guard;
                sat_inf = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 multiplier: one multiplier bit per cycle through a shift-add
// accumulator, then a single normalise/round/pack cycle. One operation in flight.
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_seq_if.slave  bus,
    output state_e       state_dbg
);

    localparam int SIG_W = MAN_W + 1;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int PW    = 2 * SIG_W;
    localparam int EW    = EXP_W + 2;
    localparam int CW    = $clog2(SIG_W);
    localparam int BIAS  = bias_of(EXP_W);

    localparam logic [W-1:0]         QNAN  = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    state_e state, state_nx;

    logic                  sign_q;
    logic signed [EW-1:0]  e_q;
    logic [SIG_W-1:0]      mx_q;
    logic [SIG_W-1:0]      my_q;
    logic [PW-1:0]         acc_q;
    logic [2:0]            rm_q;
    logic [CW-1:0]         cnt_q;
    logic [W-1:0]          z_q;
    logic                  ovrf_q;
    logic                  udrf_q;
    logic                  nv_q;

    // Operand decode, used only in IDLE at the accepting edge.
    logic                  sx, sy, sz;
    logic [EXP_W-1:0]      ex, ey;
    logic [MAN_W-1:0]      fx, fy;
    fp_class_e             cls_x, cls_y;
    logic                  x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic                  special;
    logic [W-1:0]          spec_z;
    logic                  spec_nv;
    logic signed [EW-1:0]  e_init;

    assign sx = bus.fp_X[W-1];
    assign sy = bus.fp_Y[W-1];
    assign ex = bus.fp_X[W-2:MAN_W];
    assign ey = bus.fp_Y[W-2:MAN_W];
    assign fx = bus.fp_X[MAN_W-1:0];
    assign fy = bus.fp_Y[MAN_W-1:0];
    assign sz = sx ^ sy;

    assign e_init = $signed({2'b00, ex}) + $signed({2'b00, ey}) - $signed(EW'(BIAS));

    always_comb begin
        cls_x = classify(ex == '0, &ex, fx == '0, fx[MAN_W-1]);
        cls_y = classify(ey == '0, &ey, fy == '0, fy[MAN_W-1]);
    end

    // Subnormals are flushed to zero on input, so they behave as zero everywhere below.
    assign x_zero  = (cls_x == FC_ZERO) || (cls_x == FC_SUB);
    assign y_zero  = (cls_y == FC_ZERO) || (cls_y == FC_SUB);
    assign x_inf   = (cls_x == FC_INF);
    assign y_inf   = (cls_y == FC_INF);
    assign x_nan   = (cls_x == FC_QNAN) || (cls_x == FC_SNAN);
    assign y_nan   = (cls_y == FC_QNAN) || (cls_y == FC_SNAN);
    assign special = !((cls_x == FC_NORM) && (cls_y == FC_NORM));

    always_comb begin
        spec_z  = {sz, {(W-1){1'b0}}};
        spec_nv = 1'b0;
        if (x_nan || y_nan) begin
            spec_z  = QNAN;
            spec_nv = (cls_x == FC_SNAN) || (cls_y == FC_SNAN);
        end else if ((x_zero && y_inf) || (x_inf && y_zero)) begin
            spec_z  = QNAN;
            spec_nv = 1'b1;
        end else if (x_inf || y_inf) begin
            spec_z  = {sz, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Shift-add step: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right so the next bit lines up.
    logic [SIG_W:0] step_sum;
    logic [PW-1:0]  acc_nx;

    assign step_sum = {1'b0, acc_q[PW-1:SIG_W]} + (my_q[0] ? {1'b0, mx_q} : '0);
    assign acc_nx   = {step_sum, acc_q[SIG_W-1:1]};

    // Normalise, round and pack the finished product.
    logic [PW-1:0]         norm;
    logic signed [EW-1:0]  e_n, e_r;
    logic [SIG_W-1:0]      sig, sig_r;
    logic [SIG_W:0]        sig_inc;
    logic                  g_bit, r_bit, s_bit;
    logic                  inc, sat_inf;
    logic                  rnd_ovrf, rnd_udrf;
    logic [W-1:0]          rnd_z;

    assign norm  = acc_q[PW-1] ? acc_q : (acc_q << 1);
    assign e_n   = acc_q[PW-1] ? (e_q + EW'(1)) : e_q;
    assign sig   = norm[PW-1:SIG_W];
    assign g_bit = norm[SIG_W-1];
    assign r_bit = norm[SIG_W-2];
    assign s_bit = |norm[SIG_W-3:0];

    fp_round u_round (
        .sign      (sign_q),
        .guard     (g_bit),
        .round_bit (r_bit),
        .sticky    (s_bit),
        .lsb       (sig[0]),
        .r_mode    (rm_q),
        .inc       (inc),
        .sat_inf   (sat_inf)
    );

    assign sig_inc = {1'b0, sig} + {{SIG_W{1'b0}}, inc};

    always_comb begin
        if (sig_inc[SIG_W]) begin
            sig_r = sig_inc[SIG_W:1];
            e_r   = e_n + EW'(1);
        end else begin
            sig_r = sig_inc[SIG_W-1:0];
            e_r   = e_n;
        end
    end

    assign rnd_ovrf = !e_r[EW-1] && (e_r >= E_MAX);
    assign rnd_udrf = !rnd_ovrf && (e_r[EW-1] || (e_r == '0));

    always_comb begin
        if (rnd_ovrf) begin
            rnd_z = sat_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (rnd_udrf) begin
            rnd_z = {sign_q, {(W-1){1'b0}}};
        end else begin
            rnd_z = {sign_q, e_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid) state_nx = special ? DONE : CALC;
            CALC: if (cnt_q == CW'(SIG_W - 1)) state_nx = RND;
            RND:  state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        state_dbg     = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            e_q    <= '0;
            mx_q   <= '0;
            my_q   <= '0;
            acc_q  <= '0;
            rm_q   <= '0;
            cnt_q  <= '0;
            z_q    <= '0;
            ovrf_q <= 1'b0;
            udrf_q <= 1'b0;
            nv_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= sz;
                        e_q    <= e_init;
                        mx_q   <= {1'b1, fx};
                        my_q   <= {1'b1, fy};
                        acc_q  <= '0;
                        rm_q   <= bus.r_mode;
                        cnt_q  <= '0;
                        if (special) begin
                            z_q    <= spec_z;
                            ovrf_q <= 1'b0;
                            udrf_q <= 1'b0;
                            nv_q   <= spec_nv;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_nx;
                    my_q  <= my_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                RND: begin
                    z_q    <= rnd_z;
                    ovrf_q <= rnd_ovrf;
                    udrf_q <= rnd_udrf;
                    nv_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.fp_Z = z_q;
    assign bus.ovrf = ovrf_q;
    assign bus.udrf = udrf_q;
    assign bus.nv   = nv_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq at binary32 widths: directed cases, handshake
// hold, mid-operation reset and random normal operands in both operand orders.
module tb_fp_mul_seq;
    import fp_mul_pkg::*;

    localparam int W  = 32;
    localparam int RW = W + 3;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_e state_dbg;

    fp_mul_seq_if #(.W(W)) bus ();

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [RW-1:0] exp_q[$];

    // Independent reference for normal*normal products: integer significand product, then rounding.
    function automatic logic [RW-1:0] model_mul(input logic [31:0] x, input logic [31:0] y,
                                                input logic [2:0] m);
        logic s, g, r, st, inc, sat;
        int e;
        logic [47:0] p;
        logic [23:0] sig;
        logic [24:0] sr;
        s = x[31] ^ y[31];
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        if (p[47]) e = e + 1;
        else       p = p << 1;
        sig = p[47:24];
        g = p[23];
        r = p[22];
        st = |p[21:0];
        case (m)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s & (g | r | st);
            3'd3:    inc = !s & (g | r | st);
            3'd4:    inc = g;
            default: inc = g & (r | st | sig[0]);
        endcase
        sr = {1'b0, sig} + 25'(inc);
        if (sr[24]) begin
            sig = sr[24:1];
            e = e + 1;
        end else begin
            sig = sr[23:0];
        end
        if (e >= 255) begin
            sat = (m == 3'd1) ? 1'b0 : (m == 3'd2) ? s : (m == 3'd3) ? !s : 1'b1;
            return sat ? {3'b100, s, 8'hFF, 23'h0} : {3'b100, s, 8'hFE, 23'h7FFFFF};
        end
        if (e <= 0) return {3'b010, s, 31'h0};
        return {3'b000, s, e[7:0], sig[22:0]};
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] m);
        int guard = 0;
        bus.fp_X = x;
        bus.fp_Y = y;
        bus.r_mode = m;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL accept: in_ready=%b required 1 within 200 cycles", bus.in_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.fp_X = $urandom;
        bus.fp_Y = $urandom;
        bus.r_mode = 3'($urandom_range(0, 7));
    endtask

    // Waits for the result, then completes the output handshake.
    task automatic get_result(output logic [RW-1:0] got, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        lat++;
        got = bus.out_valid ? {bus.ovrf, bus.udrf, bus.nv, bus.fp_Z} : 'x;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || state_dbg !== IDLE)
            $display("FAIL reset_ctrl: in_ready/out_valid=%b%b state=%0d required 10 state=0",
                     bus.in_ready, bus.out_valid, state_dbg);
        else n_pass++;
        n_checks++;
        if ({bus.ovrf, bus.udrf, bus.nv, bus.fp_Z} !== '0)
            $display("FAIL reset_data: got=%h required 0", {bus.ovrf, bus.udrf, bus.nv, bus.fp_Z});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        logic [RW-1:0] got, e;
        int lat;
        exp_q.push_back({3'b000, 32'h40F00000});
        send(32'h40400000, 32'h40200000, 3'b000);
        get_result(got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL normal: got=%h required=%h", got, e);
        else n_pass++;
        n_checks++;
        if (lat != 26) $display("FAIL normal_latency: got=%0d required=26", lat);
        else n_pass++;
    endtask

    task automatic test_rounding;
        logic [2:0]  modes[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        logic [31:0] zs[6]    = '{32'h3F800002, 32'h3F800002, 32'h3F800002, 32'h3F800003,
                                  32'h3F800002, 32'h3F800002};
        logic [RW-1:0] got, e;
        int lat;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({3'b000, zs[i]});
            send(32'h3F800001, 32'h3F800001, modes[i]);
            get_result(got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL rounding mode=%0d: got=%h required=%h", modes[i], got, e);
            else n_pass++;
        end
    endtask

    task automatic test_overflow;
        logic [31:0] xs[6]    = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF,
                                  32'hFF7FFFFF, 32'hFF7FFFFF};
        logic [2:0]  modes[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3};
        logic [31:0] zs[6]    = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000,
                                  32'hFF800000, 32'hFF7FFFFF};
        logic [RW-1:0] got, e;
        int lat;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({3'b100, zs[i]});
            send(xs[i], 32'h40000000, modes[i]);
            get_result(got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL overflow case=%0d: got=%h required=%h", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_special;
        logic [31:0]   xs[7]   = '{32'h00800000, 32'h00000000, 32'h7F800001, 32'hFFC00000,
                                   32'hFF800000, 32'h00000001, 32'h80000000};
        logic [31:0]   ys[7]   = '{32'h3F000000, 32'h7F800000, 32'h3F800000, 32'h40000000,
                                   32'h40000000, 32'hC0000000, 32'h40400000};
        logic [RW-1:0] res[7]  = '{{3'b010, 32'h00000000}, {3'b001, 32'h7FC00000},
                                   {3'b001, 32'h7FC00000}, {3'b000, 32'h7FC00000},
                                   {3'b000, 32'hFF800000}, {3'b000, 32'h80000000},
                                   {3'b000, 32'h80000000}};
        int            lats[7] = '{26, 1, 1, 1, 1, 1, 1};
        logic [RW-1:0] got, e;
        int lat;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(res[i]);
            send(xs[i], ys[i], 3'b000);
            get_result(got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL special case=%0d: got=%h required=%h", i, got, e);
            else n_pass++;
            n_checks++;
            if (lat != lats[i]) $display("FAIL special_latency case=%0d: got=%0d required=%0d", i, lat, lats[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold;
        logic [RW-1:0] e;
        int lat = 0;
        exp_q.push_back({3'b000, 32'h3F800003});
        send(32'h3F800001, 32'h3F800001, 3'b011);
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.ovrf, bus.udrf, bus.nv, bus.fp_Z} !== e || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                $display("FAIL hold cycle=%0d: got=%h in_ready=%b out_valid=%b required=%h 0 1",
                         i, {bus.ovrf, bus.udrf, bus.nv, bus.fp_Z}, bus.in_ready, bus.out_valid, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL hold_release: in_ready/out_valid=%b%b required 10", bus.in_ready, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [RW-1:0] got, e;
        int lat;
        send(32'h40400000, 32'h40200000, 3'b000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || state_dbg !== IDLE || bus.fp_Z !== '0)
            $display("FAIL reset_mid: in_ready/out_valid=%b%b state=%0d fp_Z=%h required 10 0 0",
                     bus.in_ready, bus.out_valid, state_dbg, bus.fp_Z);
        else n_pass++;
        rst_n = 1'b1;
        exp_q.push_back({3'b000, 32'h40F00000});
        send(32'h40400000, 32'h40200000, 3'b000);
        get_result(got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL reset_recover: got=%h required=%h", got, e);
        else n_pass++;
    endtask

    task automatic test_random_commute;
        logic [31:0] x, y;
        logic [2:0] m;
        logic [RW-1:0] got, e;
        int lat;
        for (int i = 0; i < 12; i++) begin
            x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            y = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
            m = 3'($urandom_range(0, 7));
            for (int k = 0; k < 2; k++) begin
                exp_q.push_back(model_mul(x, y, m));
                if (k == 0) send(x, y, m);
                else        send(y, x, m);
                get_result(got, lat);
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e || lat != 26)
                    $display("FAIL random i=%0d swap=%0d x=%h y=%h mode=%0d: got=%h lat=%0d required=%h lat=26",
                             i, k, x, y, m, got, lat, e);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.fp_X      = '0;
        bus.fp_Y      = '0;
        bus.r_mode    = 3'b000;
        bus.out_ready = 1'b0;
        test_reset();
        test_normal();
        test_rounding();
        test_overflow();
        test_special();
        test_hold();
        test_reset_mid();
        test_random_commute();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
